bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Parametrised, multi-cycle binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) algorithm and processes one input bit per clock. It replaces the fixed 7-bit combinational converter on display and telemetry paths where input widths grow beyond 7 bits. A single shift datapath serves any width, which saves area. The block uses a start/done handshake so producers can issue conversions back-to-back, and it flags values that do not fit in the configured number of digits.

## Interface
- BIN_W, 7: binary input width; legal range 1..32.
- DIGITS, 3: number of BCD output digits. Must be at least 1. DIGITS*4 < BIN_W is legal; overflow then reports through `ovf`.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a conversion of `bin`. Accepted only while `busy`=0.
- bin  in  BIN_W  unsigned binary value. Sampled only on the accepting cycle.
- busy  out  1  high from the cycle after acceptance through the DONE cycle inclusive.
- done  out  1  one-cycle pulse; `bcd` and `ovf` are valid from this cycle on.
- bcd  out  4*DIGITS  packed BCD. Digit k sits at bits [4k+3:4k]; digit 0 is the least significant.
- ovf  out  1  set when the value exceeds 10^DIGITS − 1.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: runs BIN_W iterations.
  - DONE: outputs the result for one cycle.
- IDLE → SHIFT on `start`. On that edge:
  - latch `bin` into the input shift register;
  - clear the working BCD register and the overflow accumulator;
  - load the counter with BIN_W.
- SHIFT, one iteration per cycle:
  - Every working digit ≥ 5 has 3 added (4-bit, no carry out).
  - The corrected register is then shifted left by one, with the input register's MSB entering at bit 0.
  - The bit shifted out of the top digit is ORed into the overflow accumulator.
  - The input register shifts left and the counter decrements.
- SHIFT → DONE when the counter reaches 0, i.e. after exactly BIN_W iterations.
- DONE:
  - copy the working register into `bcd` and the accumulator into `ovf`;
  - assert `done`;
  - go to IDLE on the next edge.
- With overflow, `bcd` holds the value mod 10^DIGITS. Lower digits are always correct.
- `start` while `busy`=1 is ignored; it is neither queued nor errored. `start` is accepted in the cycle after DONE.
- `bcd` and `ovf` hold their values until the next DONE. Intermediate values never appear on `bcd`.
- BIN_W=1 is legal: one SHIFT iteration.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `bcd`=0, `ovf`=0;
  - counter and working registers cleared.
- Reset mid-conversion aborts the conversion. Nothing is reported, `done` is not pulsed, and outputs go to their reset values on the reset edge.
- Reset has priority over `start` on the same edge.
- Latency: with `start` sampled at edge T, `done`=1 during cycle T+BIN_W+1.
- Throughput: one conversion per BIN_W+2 cycles if `start` is held high.
- Corrections are combinational within one cycle. The critical path is one 4-bit add-3 stage plus the shift mux per digit.

## Structure
- Shared package/header `bcd_pkg` holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - BCD_DIGIT_W=4;
  - a function giving the minimum DIGITS for a given BIN_W, used for elaboration-time checks.
- Sub-module `bcd_digit_adj`: combinational. 4-bit digit in; output is digit+3 if the digit ≥ 5, else the digit unchanged. Instantiate it DIGITS times in a generate loop.
- Elaboration check: fail if BIN_W is outside 1..32 or DIGITS < 1.

## Test plan
- BIN_W=7, DIGITS=3, `bin`=127, single `start` → `done` at T+8, `bcd`=12'h127, `ovf`=0, `busy` high for 8 cycles.
- BIN_W=7, `bin`=0 and then `bin`=99 back-to-back with `start` held high → 12'h000, then 12'h099. Second `done` arrives 9 cycles after the first.
- BIN_W=10, DIGITS=3: `bin`=999 → 12'h999, `ovf`=0; `bin`=1023 → 12'h023, `ovf`=1.
- `start` pulsed with `bin`=55 mid-conversion of `bin`=42 → only one `done`, `bcd`=12'h042. `bin` changing after acceptance has no effect.
- `rst` asserted 3 cycles into a conversion → next cycle `busy`=0, `bcd`=0, and no `done` pulse. A new `start` one cycle after reset is released converts correctly.
- Exhaustive sweep, BIN_W=7 and BIN_W=12 (DIGITS=4): every input value is checked against a reference model for `bcd` and `ovf`.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// BCD digit width and an elaboration helper sizing the digit count for a width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Decimal digits needed to show 2**bin_w - 1 without overflow.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/done handshake and overflow flag when the value exceeds DIGITS digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W=%0d outside 1..32", BIN_W);
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d must be at least 1", DIGITS);
  end

  state_e            state_q;
  logic [BIN_W-1:0]  bin_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [BCD_W-1:0]  work_q;
  logic [BCD_W-1:0]  work_d;
  logic [BCD_W-1:0]  adj;
  logic              acc_q;
  logic              acc_d;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [BCD_W-1:0]  bcd_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Carry out of the top digit can only ever be set when the width can overflow.
  always_comb begin
    work_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    acc_d  = OVF_POSSIBLE ? (acc_q | adj[BCD_W-1]) : 1'b0;
    cnt_d  = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin;
            work_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          acc_q  <= acc_d;
          bin_q  <= bin_q << 1;
          cnt_q  <= cnt_d;
          // Result is captured on entry to DONE so it is already valid while done is high.
          if (cnt_d == '0) begin
            bcd_q   <= work_d;
            ovf_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule
